// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between predictor, execute stage and branch_resolve_queue.
// The master modport is the environment view; slave is the queue's view.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
);
  // Prediction push side
  logic        predValid;
  logic        predReady;
  logic [31:0] predPC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic [2:0]  branchT;

  // Execute side
  logic        exValid;
  logic [31:0] exPC;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] exTarget;

  // Resolve / training / redirect side
  logic                    branchResolved;
  logic                    actualTaken;
  logic [31:0]             resolvedPC;
  logic [2:0]              resolvedT;
  logic                    redirectValid;
  logic [31:0]             redirectPC;
  logic                    orderError;
  logic [CNTW-1:0]         mispredictCount;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output predValid, predPC, predTaken, predTarget, branchT,
    output exValid, exPC, rs1Data, rs2Data, exTarget,
    input  predReady, branchResolved, actualTaken, resolvedPC, resolvedT,
    input  redirectValid, redirectPC, orderError, mispredictCount, occupancy
  );

  modport slave (
    input  predValid, predPC, predTaken, predTarget, branchT,
    input  exValid, exPC, rs1Data, rs2Data, exTarget,
    output predReady, branchResolved, actualTaken, resolvedPC, resolvedT,
    output redirectValid, redirectPC, orderError, mispredictCount, occupancy
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction FIFO: resolves RV32 branch conditions, trains the predictor,
// redirects fetch and flushes on mispredict. Define BRQ_TARGET_CHECK_EN to also flag wrong targets.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_queue_if.slave bus
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic evalCond(input logic [2:0]  funct3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               res;
    sa = signed'(a);
    sb = signed'(b);
    case (funct3)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b100:  res = (sa < sb);
      3'b101:  res = (sa >= sb);
      3'b110:  res = (a < b);
      3'b111:  res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Queue storage carries no reset; validity is tracked entirely by the pointers
  logic [31:0] qPC    [DEPTH];
  logic        qTaken [DEPTH];
  logic [2:0]  qType  [DEPTH];
`ifdef BRQ_TARGET_CHECK_EN
  logic [31:0] qTarget[DEPTH];
`endif

  logic [AW-1:0] headPtr;
  logic [AW-1:0] tailPtr;
  logic [AW:0]   count;
  logic [AW:0]   countNext;
  logic          rdy_p1;

  logic [31:0]   headPC_p0;
  logic          headTaken_p0;
  logic [2:0]    headT_p0;
  logic          empty_p0;
  logic          pop_p0;
  logic          push_p0;
  logic          cond_p0;
  logic          targetMiss_p0;
  logic          mispred_p0;
  logic          badOrder_p0;

  logic            vld_p1;
  logic            actual_p1;
  logic [31:0]     resolvedPC_p1;
  logic [2:0]      resolvedT_p1;
  logic            redirect_p1;
  logic [31:0]     redirectPC_p1;
  logic            orderErr_p1;
  logic [CNTW-1:0] missCnt_p1;

  // ---- Stage 0: head lookup, condition evaluation, push/pop decision ----
  always_comb begin
    headPC_p0    = qPC[headPtr];
    headTaken_p0 = qTaken[headPtr];
    headT_p0     = qType[headPtr];
    empty_p0     = (count == '0);
    pop_p0       = bus.exValid && !empty_p0;
    cond_p0      = evalCond(headT_p0, bus.rs1Data, bus.rs2Data);
`ifdef BRQ_TARGET_CHECK_EN
    targetMiss_p0 = headTaken_p0 && cond_p0 && (qTarget[headPtr] != bus.exTarget);
`else
    targetMiss_p0 = 1'b0;
`endif
    mispred_p0   = pop_p0 && ((headTaken_p0 != cond_p0) || targetMiss_p0);
    // A flush drops any push arriving in the same cycle
    push_p0      = bus.predValid && rdy_p1 && !mispred_p0;
    badOrder_p0  = bus.exValid && (empty_p0 || (bus.exPC != headPC_p0));
  end

  always_comb begin
    countNext = count;
    if (push_p0 && !pop_p0) countNext = count + (AW+1)'(1);
    if (pop_p0 && !push_p0) countNext = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      qPC[tailPtr]    <= bus.predPC;
      qTaken[tailPtr] <= bus.predTaken;
      qType[tailPtr]  <= bus.branchT;
`ifdef BRQ_TARGET_CHECK_EN
      qTarget[tailPtr] <= bus.predTarget;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      rdy_p1  <= 1'b0;
    end else if (mispred_p0) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      rdy_p1  <= 1'b1;
    end else begin
      headPtr <= headPtr + AW'(pop_p0);
      tailPtr <= tailPtr + AW'(push_p0);
      count   <= countNext;
      rdy_p1  <= (countNext != FULL_CNT);
    end
  end

  // ---- Stage 1: registered resolve, training and redirect outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      actual_p1     <= 1'b0;
      resolvedPC_p1 <= '0;
      resolvedT_p1  <= '0;
      redirect_p1   <= 1'b0;
      redirectPC_p1 <= '0;
      orderErr_p1   <= 1'b0;
      missCnt_p1    <= '0;
    end else begin
      vld_p1      <= pop_p0;
      redirect_p1 <= mispred_p0;
      orderErr_p1 <= orderErr_p1 | badOrder_p0;
      if (pop_p0) begin
        actual_p1     <= cond_p0;
        resolvedPC_p1 <= headPC_p0;
        resolvedT_p1  <= headT_p0;
      end
      if (mispred_p0) begin
        redirectPC_p1 <= cond_p0 ? bus.exTarget : headPC_p0 + 32'd4;
        missCnt_p1    <= satInc(missCnt_p1);
      end
    end
  end

  assign bus.predReady       = rdy_p1;
  assign bus.branchResolved  = vld_p1;
  assign bus.actualTaken     = actual_p1;
  assign bus.resolvedPC      = resolvedPC_p1;
  assign bus.resolvedT       = resolvedT_p1;
  assign bus.redirectValid   = redirect_p1;
  assign bus.redirectPC      = redirectPC_p1;
  assign bus.orderError      = orderErr_p1;
  assign bus.mispredictCount = missCnt_p1;
  assign bus.occupancy       = count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, CNTW=16); the target-check case
// adapts its expectations to BRQ_TARGET_CHECK_EN.
module tb_branch_resolve_queue;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  branch_resolve_queue_if #(.DEPTH(4), .CNTW(16)) bus ();

  branch_resolve_queue #(.DEPTH(4), .CNTW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [2:0] t);
    bus.predValid  = 1'b1;
    bus.predPC     = pc;
    bus.predTaken  = tk;
    bus.predTarget = tg;
    bus.branchT    = t;
    tick();
    bus.predValid  = 1'b0;
  endtask

  task automatic exec(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tg);
    bus.exValid  = 1'b1;
    bus.exPC     = pc;
    bus.rs1Data  = a;
    bus.rs2Data  = b;
    bus.exTarget = tg;
    tick();
    bus.exValid  = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset          = 1'b0;
    bus.predValid  = 1'b0;
    bus.predPC     = '0;
    bus.predTaken  = 1'b0;
    bus.predTarget = '0;
    bus.branchT    = '0;
    bus.exValid    = 1'b0;
    bus.exPC       = '0;
    bus.rs1Data    = '0;
    bus.rs2Data    = '0;
    bus.exTarget   = '0;

    // Reset state
    repeat (3) tick();
    check("rst_resolved", bus.branchResolved, 0);
    check("rst_redirect", bus.redirectValid, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_cnt", bus.mispredictCount, 0);
    check("rst_order", bus.orderError, 0);
    check("rst_ready", bus.predReady, 0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", bus.predReady, 1);

    // BEQ predicted taken, resolves taken
    push(32'h100, 1'b1, 32'h80, 3'b000);
    check("t1_occ1", bus.occupancy, 1);
    exec(32'h100, 32'd5, 32'd5, 32'h80);
    check("t1_resolved", bus.branchResolved, 1);
    check("t1_actual", bus.actualTaken, 1);
    check("t1_pc", bus.resolvedPC, 32'h100);
    check("t1_type", bus.resolvedT, 0);
    check("t1_redirect", bus.redirectValid, 0);
    check("t1_occ0", bus.occupancy, 0);
    check("t1_cnt", bus.mispredictCount, 0);
    tick();
    check("t1_pulse_end", bus.branchResolved, 0);

    // BLT signed 1 < -1 is false: mispredict, flush the younger entry
    push(32'h200, 1'b1, 32'h240, 3'b100);
    push(32'h204, 1'b0, 32'h0, 3'b000);
    check("t2_occ2", bus.occupancy, 2);
    exec(32'h200, 32'h1, 32'hFFFF_FFFF, 32'h240);
    check("t2_resolved", bus.branchResolved, 1);
    check("t2_actual", bus.actualTaken, 0);
    check("t2_type", bus.resolvedT, 4);
    check("t2_redirect", bus.redirectValid, 1);
    check("t2_redir_pc", bus.redirectPC, 32'h204);
    check("t2_occ_flush", bus.occupancy, 0);
    check("t2_cnt", bus.mispredictCount, 1);
    tick();
    check("t2_redir_end", bus.redirectValid, 0);
    check("t2_occ_stay", bus.occupancy, 0);

    // BLTU unsigned 1 < 0xFFFFFFFF is true, predicted taken: no redirect
    push(32'h208, 1'b1, 32'h300, 3'b110);
    exec(32'h208, 32'h1, 32'hFFFF_FFFF, 32'h300);
    check("t3_actual", bus.actualTaken, 1);
    check("t3_redirect", bus.redirectValid, 0);
    check("t3_redir_hold", bus.redirectPC, 32'h204);
    check("t3_cnt", bus.mispredictCount, 1);
    check("t3_type", bus.resolvedT, 6);

    // BGEU false, predicted taken: redirect to PC+4
    push(32'h20C, 1'b1, 32'h340, 3'b111);
    exec(32'h20C, 32'h1, 32'hFFFF_FFFF, 32'h340);
    check("t3b_actual", bus.actualTaken, 0);
    check("t3b_redir_pc", bus.redirectPC, 32'h210);
    check("t3b_cnt", bus.mispredictCount, 2);

    // BGE signed 1 >= -1 true, predicted not taken: redirect to exTarget
    push(32'h210, 1'b0, 32'h0, 3'b101);
    exec(32'h210, 32'h1, 32'hFFFF_FFFF, 32'h380);
    check("t3c_actual", bus.actualTaken, 1);
    check("t3c_redirect", bus.redirectValid, 1);
    check("t3c_redir_pc", bus.redirectPC, 32'h380);
    check("t3c_cnt", bus.mispredictCount, 3);

    // funct3 010 never taken, still resolves
    push(32'h214, 1'b1, 32'h3C0, 3'b010);
    exec(32'h214, 32'h0, 32'h0, 32'h3C0);
    check("t3d_resolved", bus.branchResolved, 1);
    check("t3d_actual", bus.actualTaken, 0);
    check("t3d_type", bus.resolvedT, 2);
    check("t3d_redir_pc", bus.redirectPC, 32'h218);
    check("t3d_cnt", bus.mispredictCount, 4);

    // Fill, overflow attempt, pop+push while full
    push(32'h10, 1'b0, 32'h0, 3'b000);
    push(32'h14, 1'b0, 32'h0, 3'b000);
    push(32'h18, 1'b0, 32'h0, 3'b000);
    push(32'h1C, 1'b0, 32'h0, 3'b000);
    check("t4_occ4", bus.occupancy, 4);
    check("t4_full_ready", bus.predReady, 0);
    push(32'h20, 1'b0, 32'h0, 3'b000);
    check("t4_overflow_occ", bus.occupancy, 4);
    bus.predValid = 1'b1;
    bus.predPC    = 32'h20;
    exec(32'h10, 32'h1, 32'h2, 32'h0);
    check("t4_occ3", bus.occupancy, 3);
    check("t4_pop_pc", bus.resolvedPC, 32'h10);
    check("t4_ready_back", bus.predReady, 1);
    tick();
    bus.predValid = 1'b0;
    check("t4_occ4_again", bus.occupancy, 4);
    exec(32'h14, 32'h1, 32'h2, 32'h0);
    check("t4_drain_14", bus.resolvedPC, 32'h14);
    exec(32'h18, 32'h1, 32'h2, 32'h0);
    check("t4_drain_18", bus.resolvedPC, 32'h18);
    exec(32'h1C, 32'h1, 32'h2, 32'h0);
    check("t4_drain_1c", bus.resolvedPC, 32'h1C);
    exec(32'h20, 32'h1, 32'h2, 32'h0);
    check("t4_drain_20", bus.resolvedPC, 32'h20);
    check("t4_drain_occ", bus.occupancy, 0);

    // Simultaneous push+pop while not full
    push(32'h30, 1'b0, 32'h0, 3'b000);
    bus.predValid = 1'b1;
    bus.predPC    = 32'h34;
    exec(32'h30, 32'h1, 32'h2, 32'h0);
    bus.predValid = 1'b0;
    check("t4_pp_occ", bus.occupancy, 1);
    check("t4_pp_pc", bus.resolvedPC, 32'h30);
    exec(32'h34, 32'h1, 32'h2, 32'h0);
    check("t4_pp_pc2", bus.resolvedPC, 32'h34);
    check("t4_order_clean", bus.orderError, 0);
    check("t4_cnt", bus.mispredictCount, 4);

    // exPC mismatch: still resolves with head data, flags orderError
    push(32'h100, 1'b1, 32'h180, 3'b000);
    exec(32'h300, 32'd7, 32'd7, 32'h180);
    check("t5_resolved", bus.branchResolved, 1);
    check("t5_pc", bus.resolvedPC, 32'h100);
    check("t5_order", bus.orderError, 1);
    tick();
    check("t5_order_sticky", bus.orderError, 1);

    // Reset clears orderError and counter
    reset = 1'b0;
    #1;
    check("t5_rst_order", bus.orderError, 0);
    check("t5_rst_cnt", bus.mispredictCount, 0);
    tick();
    reset = 1'b1;
    tick();

    // exValid on empty queue
    exec(32'h300, 32'h0, 32'h0, 32'h0);
    check("t5e_no_pulse", bus.branchResolved, 0);
    check("t5e_order", bus.orderError, 1);
    check("t5e_occ", bus.occupancy, 0);
    tick();
    check("t5e_sticky", bus.orderError, 1);

    // Taken BNE with wrong predicted target
    push(32'h600, 1'b1, 32'h400, 3'b001);
    exec(32'h600, 32'h1, 32'h2, 32'h500);
    check("t6_actual", bus.actualTaken, 1);
`ifdef BRQ_TARGET_CHECK_EN
    check("t6_redirect", bus.redirectValid, 1);
    check("t6_redir_pc", bus.redirectPC, 32'h500);
    check("t6_cnt", bus.mispredictCount, 1);
`else
    check("t6_redirect", bus.redirectValid, 0);
    check("t6_redir_pc", bus.redirectPC, 32'h0);
    check("t6_cnt", bus.mispredictCount, 0);
`endif

    // Reset while a mispredict pulse is out, then with a pop requested
    push(32'h700, 1'b0, 32'h0, 3'b000);
    push(32'h704, 1'b0, 32'h0, 3'b000);
    exec(32'h700, 32'd9, 32'd9, 32'h7A0);
    check("t7_pulse", bus.branchResolved, 1);
    check("t7_redir", bus.redirectValid, 1);
    reset = 1'b0;
    #1;
    check("t7_rst_pulse", bus.branchResolved, 0);
    check("t7_rst_redir", bus.redirectValid, 0);
    check("t7_rst_occ", bus.occupancy, 0);
    tick();
    reset = 1'b1;
    tick();
    push(32'h800, 1'b0, 32'h0, 3'b000);
    bus.exValid  = 1'b1;
    bus.exPC     = 32'h800;
    bus.rs1Data  = 32'd3;
    bus.rs2Data  = 32'd3;
    bus.exTarget = 32'h8A0;
    #2;
    reset = 1'b0;
    tick();
    bus.exValid = 1'b0;
    reset = 1'b1;
    tick();
    check("t7b_no_pulse", bus.branchResolved, 0);
    check("t7b_no_redir", bus.redirectValid, 0);
    check("t7b_occ", bus.occupancy, 0);
    tick();
    check("t7b_no_pulse2", bus.branchResolved, 0);
    check("t7b_cnt", bus.mispredictCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
